// File: rtl/button_pkg.sv
// ---------------------------------------------------------------------------
// button_pkg
// Shared constants and types for the push-button conditioning stage.
//   NUM_BTN             : number of button channels
//   DEBOUNCE_CYCLES_DEF : default stability window in synchronized cycles
//   LONG_CYCLES_DEF     : default hold time before the long-press strobe
//   db_state_e          : per-channel filter state
// ---------------------------------------------------------------------------
`timescale 1ns/100ps

package button_pkg;

   localparam int NUM_BTN             = 4;
   localparam int DEBOUNCE_CYCLES_DEF = 16;
   localparam int LONG_CYCLES_DEF     = 64;

   typedef enum logic {
      DB_STABLE  = 1'b0,
      DB_PENDING = 1'b1
   } db_state_e;

endpackage : button_pkg

// File: rtl/debounce_ch.sv
// ---------------------------------------------------------------------------
// debounce_ch
// One button channel: 2-flop synchronizer, stability-counter filter FSM,
// registered press/release strobes and an optional long-press detector.
// Optional feature macro: BUTTON_DEBOUNCE_LONG_PRESS_EN (adds hold counter;
// without it long_pulse is constant 0).
// Ports:
//   clk        in  system clock
//   reset      in  asynchronous, active-high reset
//   btn_raw    in  raw asynchronous button pin
//   level      out debounced level
//   press      out one-cycle strobe in the first cycle level reads 1
//   rls        out one-cycle strobe in the first cycle level reads 0
//   long_pulse out one-cycle strobe LONG_CYCLES cycles after press
// ---------------------------------------------------------------------------
`timescale 1ns/100ps

module debounce_ch
   import button_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int LONG_CYCLES     = LONG_CYCLES_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_raw,
   output logic level,
   output logic press,
   output logic rls,
   output logic long_pulse
);

   localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   // Elaboration-time guard against illegal configurations.
   if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES < 1) begin : g_param_check
      $error("debounce_ch: DEBOUNCE_CYCLES must be >= 2 and LONG_CYCLES >= 1");
   end

   logic             sync1_q, sync2_q;
   db_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             level_q, level_d;
   logic             press_q, press_d;
   logic             rls_q, rls_d;

   // Filter: the counter only advances while the synchronized sample
   // disagrees with the accepted level, so it can never exceed CNT_LAST.
   always_comb begin
      // NOTE: every output of this block gets a default first so no path
      // leaves a value unassigned, which would infer a latch.
      state_d = state_q;
      cnt_d   = cnt_q;
      level_d = level_q;
      press_d = 1'b0;
      rls_d   = 1'b0;
      case (state_q)
         DB_STABLE: begin
            if (sync2_q != level_q) begin
               state_d = DB_PENDING;
               cnt_d   = cnt_q + 1'b1;
            end
         end
         DB_PENDING: begin
            if (sync2_q == level_q) begin
               // Bounce ended before the window: discard progress.
               state_d = DB_STABLE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = DB_STABLE;
               cnt_d   = '0;
               level_d = ~level_q;
               press_d = ~level_q;
               rls_d   = level_q;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = DB_STABLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         state_q <= DB_STABLE;
         cnt_q   <= '0;
         level_q <= 1'b0;
         press_q <= 1'b0;
         rls_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the values
         // from before this edge, regardless of statement order.
         sync1_q <= btn_raw;
         sync2_q <= sync1_q;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         press_q <= press_d;
         rls_q   <= rls_d;
      end
   end

   assign level = level_q;
   assign press = press_q;
   assign rls   = rls_q;

`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
   localparam int               HOLD_W   = $clog2(LONG_CYCLES + 1);
   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYCLES);

   logic [HOLD_W-1:0] hold_q, hold_d;
   logic              long_q, long_d;

   // Saturating hold counter: the strobe fires only on the transition into
   // HOLD_MAX, so at most once per press.
   always_comb begin
      hold_d = hold_q;
      long_d = 1'b0;
      if (!level_q) begin
         hold_d = '0;
      end else if (hold_q != HOLD_MAX) begin
         hold_d = hold_q + 1'b1;
         long_d = (hold_d == HOLD_MAX);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hold_q <= '0;
         long_q <= 1'b0;
      end else begin
         hold_q <= hold_d;
         long_q <= long_d;
      end
   end

   assign long_pulse = long_q;
`else
   assign long_pulse = 1'b0;
`endif

endmodule : debounce_ch

// File: rtl/button_debounce.sv
// ---------------------------------------------------------------------------
// button_debounce
// Conditions the four raw push-button pins into clean levels and one-cycle
// press/release/long-press strobes for the downstream button/LED block.
// Optional feature macro: BUTTON_DEBOUNCE_LONG_PRESS_EN (btn_long is
// constant 0 when undefined; port list is unchanged).
// Ports:
//   clk          in  system clock
//   reset        in  asynchronous, active-high reset
//   BUTTON0..3   in  raw asynchronous buttons, active-high when pressed
//   btn_level    out debounced levels, bit i = BUTTONi
//   btn_press    out one-cycle strobe on each rising btn_level bit
//   btn_release  out one-cycle strobe on each falling btn_level bit
//   btn_long     out one-cycle long-press strobe
// ---------------------------------------------------------------------------
`timescale 1ns/100ps

module button_debounce
   import button_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int LONG_CYCLES     = LONG_CYCLES_DEF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       BUTTON0,
   input  logic       BUTTON1,
   input  logic       BUTTON2,
   input  logic       BUTTON3,
   output logic [3:0] btn_level,
   output logic [3:0] btn_press,
   output logic [3:0] btn_release,
   output logic [3:0] btn_long
);

   logic [NUM_BTN-1:0] btn_raw;

   assign btn_raw = {BUTTON3, BUTTON2, BUTTON1, BUTTON0};

   for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
      debounce_ch #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .LONG_CYCLES     (LONG_CYCLES)
      ) u_ch (
         .clk        (clk),
         .reset      (reset),
         .btn_raw    (btn_raw[i]),
         .level      (btn_level[i]),
         .press      (btn_press[i]),
         .rls        (btn_release[i]),
         .long_pulse (btn_long[i])
      );
   end

endmodule : button_debounce

// File: tb/tb_button_debounce.sv
// ---------------------------------------------------------------------------
// tb_button_debounce
// Directed bench for button_debounce (DEBOUNCE_CYCLES=16, LONG_CYCLES=64,
// 2 ns clock). Outputs are sampled on the falling edge; "edge N" below means
// the Nth rising edge after the stimulus change.
// ---------------------------------------------------------------------------
`timescale 1ns/100ps

module tb_button_debounce;

`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
   localparam bit LONG_EN = 1'b1;
`else
   localparam bit LONG_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic       BUTTON0, BUTTON1, BUTTON2, BUTTON3;
   logic [3:0] btn_level, btn_press, btn_release, btn_long;

   int total = 0;
   int bad   = 0;

   button_debounce #(
      .DEBOUNCE_CYCLES (16),
      .LONG_CYCLES     (64)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .BUTTON0     (BUTTON0),
      .BUTTON1     (BUTTON1),
      .BUTTON2     (BUTTON2),
      .BUTTON3     (BUTTON3),
      .btn_level   (btn_level),
      .btn_press   (btn_press),
      .btn_release (btn_release),
      .btn_long    (btn_long)
   );

   always #1 clk = ~clk;

   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic expect_out(input string tag, input logic [3:0] lvl, input logic [3:0] prs,
                             input logic [3:0] rls, input logic [3:0] lng);
      check({tag, ".level"},   btn_level,   lvl);
      check({tag, ".press"},   btn_press,   prs);
      check({tag, ".release"}, btn_release, rls);
      check({tag, ".long"},    btn_long,    lng);
   endtask

   // Advance n rising edges, then settle on the following falling edge.
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      reset   = 1'b1;
      BUTTON0 = 1'b1;
      BUTTON1 = 1'b0;
      BUTTON2 = 1'b0;
      BUTTON3 = 1'b0;

      // Reset held 25 cycles with BUTTON0 pressed: nothing leaks out.
      step(1);
      expect_out("rst_early", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      step(24);
      expect_out("rst_late", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      reset = 1'b0;
      step(17);
      expect_out("rst_e17", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      step(1);
      expect_out("rst_e18", 4'b0001, 4'b0001, 4'b0000, 4'b0000);
      step(1);
      expect_out("rst_e19", 4'b0001, 4'b0000, 4'b0000, 4'b0000);
      BUTTON0 = 1'b0;
      step(17);
      expect_out("rst_rel_e17", 4'b0001, 4'b0000, 4'b0000, 4'b0000);
      step(1);
      expect_out("rst_rel_e18", 4'b0000, 4'b0000, 4'b0001, 4'b0000);
      step(1);
      expect_out("rst_rel_e19", 4'b0000, 4'b0000, 4'b0000, 4'b0000);

      // Clean press on BUTTON2 for 100 cycles, long strobe at press+64.
      BUTTON2 = 1'b1;
      step(17);
      expect_out("b2_e17", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      step(1);
      expect_out("b2_e18", 4'b0100, 4'b0100, 4'b0000, 4'b0000);
      step(1);
      expect_out("b2_e19", 4'b0100, 4'b0000, 4'b0000, 4'b0000);
      step(62);
      expect_out("b2_e81", 4'b0100, 4'b0000, 4'b0000, 4'b0000);
      step(1);
      expect_out("b2_e82", 4'b0100, 4'b0000, 4'b0000, LONG_EN ? 4'b0100 : 4'b0000);
      step(1);
      expect_out("b2_e83", 4'b0100, 4'b0000, 4'b0000, 4'b0000);
      step(17);
      expect_out("b2_e100", 4'b0100, 4'b0000, 4'b0000, 4'b0000);
      BUTTON2 = 1'b0;
      step(17);
      expect_out("b2_rel_e17", 4'b0100, 4'b0000, 4'b0000, 4'b0000);
      step(1);
      expect_out("b2_rel_e18", 4'b0000, 4'b0000, 4'b0100, 4'b0000);
      step(1);
      expect_out("b2_rel_e19", 4'b0000, 4'b0000, 4'b0000, 4'b0000);

      // Bounce on BUTTON1: toggle every 3 cycles for 60 cycles.
      for (int t = 0; t < 20; t++) begin
         BUTTON1 = (t % 2 == 0);
         for (int c = 0; c < 3; c++) begin
            step(1);
            expect_out("bounce", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
         end
      end
      BUTTON1 = 1'b0;
      step(20);
      expect_out("bounce_end", 4'b0000, 4'b0000, 4'b0000, 4'b0000);

      // Simultaneous press on BUTTON3 and BUTTON0.
      BUTTON3 = 1'b1;
      BUTTON0 = 1'b1;
      step(17);
      expect_out("sim_e17", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      step(1);
      expect_out("sim_e18", 4'b1001, 4'b1001, 4'b0000, 4'b0000);
      step(1);
      expect_out("sim_e19", 4'b1001, 4'b0000, 4'b0000, 4'b0000);
      BUTTON3 = 1'b0;
      BUTTON0 = 1'b0;
      step(18);
      expect_out("sim_rel_e18", 4'b0000, 4'b0000, 4'b1001, 4'b0000);
      step(1);
      expect_out("sim_rel_e19", 4'b0000, 4'b0000, 4'b0000, 4'b0000);

      // Reset mid-count: BUTTON3 accepted, BUTTON1 10 cycles into its window.
      BUTTON3 = 1'b1;
      step(18);
      expect_out("mid_b3", 4'b1000, 4'b1000, 4'b0000, 4'b0000);
      BUTTON1 = 1'b1;
      step(10);
      expect_out("mid_pre", 4'b1000, 4'b0000, 4'b0000, 4'b0000);
      #0.5 reset = 1'b1;
      #0.1;
      expect_out("mid_async", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      @(negedge clk);
      expect_out("mid_hold", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      reset = 1'b0;
      step(17);
      expect_out("mid_e17", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      step(1);
      expect_out("mid_e18", 4'b1010, 4'b1010, 4'b0000, 4'b0000);
      step(1);
      expect_out("mid_e19", 4'b1010, 4'b0000, 4'b0000, 4'b0000);
      BUTTON1 = 1'b0;
      BUTTON3 = 1'b0;
      step(18);
      expect_out("mid_rel_e18", 4'b0000, 4'b0000, 4'b1010, 4'b0000);
      step(1);
      expect_out("mid_rel_e19", 4'b0000, 4'b0000, 4'b0000, 4'b0000);

      // Long press: BUTTON0 held 120 cycles.
      BUTTON0 = 1'b1;
      step(18);
      expect_out("long_e18", 4'b0001, 4'b0001, 4'b0000, 4'b0000);
      step(63);
      expect_out("long_e81", 4'b0001, 4'b0000, 4'b0000, 4'b0000);
      step(1);
      expect_out("long_e82", 4'b0001, 4'b0000, 4'b0000, LONG_EN ? 4'b0001 : 4'b0000);
      step(1);
      expect_out("long_e83", 4'b0001, 4'b0000, 4'b0000, 4'b0000);
      step(37);
      expect_out("long_e120", 4'b0001, 4'b0000, 4'b0000, 4'b0000);
      BUTTON0 = 1'b0;
      step(18);
      expect_out("long_rel_e18", 4'b0000, 4'b0000, 4'b0001, 4'b0000);
      step(1);
      expect_out("long_rel_e19", 4'b0000, 4'b0000, 4'b0000, 4'b0000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_button_debounce
